// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with two async read ports, one write port and busy scoreboard
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] write_data,
  input  logic [DEPTH-1:0] write_register,
  input  logic             wr,
  input  logic             rsv,
  input  logic [DEPTH-1:0] rsv_register,
  input  logic [DEPTH-1:0] read_register_1,
  input  logic [DEPTH-1:0] read_register_2,
  output logic [WIDTH-1:0] read_data_1,
  output logic [WIDTH-1:0] read_data_2,
  output logic             busy_1,
  output logic             busy_2,
  output logic [DEPTH:0]   busy_count,
  output logic             rsv_err
);

  localparam int N = 2 ** DEPTH;

  logic [WIDTH-1:0] mem [N];
  logic [N-1:0]     busy;
  logic [N-1:0]     busy_next;

  logic wr_eff;
  logic rsv_eff;
  logic same_reg;
  logic cnt_inc;
  logic cnt_dec;
  logic err_set;

  // Register 0 swallows writes and reservations when it is hardwired to zero.
  assign wr_eff   = wr  && !((ZERO_REG != 0) && (write_register == '0));
  assign rsv_eff  = rsv && !((ZERO_REG != 0) && (rsv_register == '0));
  assign same_reg = (write_register == rsv_register);

  // Count moves only on real 0->1 / 1->0 transitions of a busy bit, so it cannot overflow or underflow.
  assign cnt_inc = rsv_eff && !busy[rsv_register];
  assign cnt_dec = wr_eff && busy[write_register] && !(rsv_eff && same_reg);
  // Re-reserving a busy register is only an error when no write-back retires it in the same cycle.
  assign err_set = rsv_eff && busy[rsv_register] && !(wr_eff && same_reg);

  // Next busy vector: write-back clears first, then reservation sets, so a new producer wins.
  always_comb begin
    busy_next = busy;
    if (wr_eff) begin
      busy_next[write_register] = 1'b0;
    end
    if (rsv_eff) begin
      busy_next[rsv_register] = 1'b1;
    end
  end

  // Storage, scoreboard, counter and sticky error, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
      busy       <= '0;
      busy_count <= '0;
      rsv_err    <= 1'b0;
    end else begin
      if (wr_eff) begin
        mem[write_register] <= write_data;
      end
      busy       <= busy_next;
      busy_count <= busy_count + {{DEPTH{1'b0}}, cnt_inc} - {{DEPTH{1'b0}}, cnt_dec};
      if (err_set) begin
        rsv_err <= 1'b1;
      end
    end
  end

  // Read port 1: stored value, optionally overridden by the in-flight write, then by the zero register.
  always_comb begin
    read_data_1 = mem[read_register_1];
    busy_1      = busy[read_register_1];
    if ((BYPASS != 0) && wr_eff && (write_register == read_register_1)) begin
      read_data_1 = write_data;
      busy_1      = 1'b0;
    end
    if ((ZERO_REG != 0) && (read_register_1 == '0)) begin
      read_data_1 = '0;
      busy_1      = 1'b0;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    read_data_2 = mem[read_register_2];
    busy_2      = busy[read_register_2];
    if ((BYPASS != 0) && wr_eff && (write_register == read_register_2)) begin
      read_data_2 = write_data;
      busy_2      = 1'b0;
    end
    if ((ZERO_REG != 0) && (read_register_2 == '0)) begin
      read_data_2 = '0;
      busy_2      = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb in bypass/zero and plain configurations
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] write_data;
  logic [4:0]  write_register;
  logic        wr;
  logic        rsv;
  logic [4:0]  rsv_register;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_b1, a_b2, b_b1, b_b2;
  logic [5:0]  a_cnt, b_cnt;
  logic        a_err, b_err;

  localparam int RD1 = 0, RD2 = 1, BZ1 = 2, BZ2 = 3, CNT = 4, ERR = 5, OFS_B = 8;

  int n_vec = 0;
  int n_err = 0;

  string       tag_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  reg_file_sb #(.WIDTH(32), .DEPTH(5), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .write_data(write_data), .write_register(write_register), .wr(wr),
    .rsv(rsv), .rsv_register(rsv_register), .read_register_1(read_register_1),
    .read_register_2(read_register_2), .read_data_1(a_rd1), .read_data_2(a_rd2),
    .busy_1(a_b1), .busy_2(a_b2), .busy_count(a_cnt), .rsv_err(a_err)
  );

  reg_file_sb #(.WIDTH(32), .DEPTH(5), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .write_data(write_data), .write_register(write_register), .wr(wr),
    .rsv(rsv), .rsv_register(rsv_register), .read_register_1(read_register_1),
    .read_register_2(read_register_2), .read_data_1(b_rd1), .read_data_2(b_rd2),
    .busy_1(b_b1), .busy_2(b_b2), .busy_count(b_cnt), .rsv_err(b_err)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      RD1:         return a_rd1;
      RD2:         return a_rd2;
      BZ1:         return {31'd0, a_b1};
      BZ2:         return {31'd0, a_b2};
      CNT:         return {26'd0, a_cnt};
      ERR:         return {31'd0, a_err};
      OFS_B + RD1: return b_rd1;
      OFS_B + RD2: return b_rd2;
      OFS_B + BZ1: return {31'd0, b_b1};
      OFS_B + BZ2: return {31'd0, b_b2};
      OFS_B + CNT: return {26'd0, b_cnt};
      OFS_B + ERR: return {31'd0, b_err};
      default:     return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  // Expectation for the same output of both instances.
  task automatic push2(input string tag, input int sel, input logic [31:0] va, input logic [31:0] vb);
    push({tag, "_a"}, sel, va);
    push({tag, "_b"}, sel + OFS_B, vb);
  endtask

  task automatic drain();
    #1;
    while (sel_q.size() > 0) begin
      check(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    wr  = 1'b0;
    rsv = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; write_data = '0; write_register = '0; wr = 1'b0;
    rsv = 1'b0; rsv_register = '0; read_register_1 = 5'd3; read_register_2 = 5'd7;
    push2("rst_rd1", RD1, 0, 0);
    push2("rst_b1", BZ1, 0, 0);
    push2("rst_cnt", CNT, 0, 0);
    push2("rst_err", ERR, 0, 0);
    drain();
    #6 rst = 1'b1;
    cyc();

    // write r3 with bypass visible same cycle only on the bypassing instance
    wr = 1'b1; write_register = 5'd3; write_data = 32'hDEADBEEF; read_register_1 = 5'd3;
    push2("byp_rd1", RD1, 32'hDEADBEEF, 32'h0);
    push2("byp_b1", BZ1, 0, 0);
    drain();
    cyc();
    push2("wr_rd1", RD1, 32'hDEADBEEF, 32'hDEADBEEF);
    drain();

    // reserve r5, hold for a few cycles, then write it back
    rsv = 1'b1; rsv_register = 5'd5; read_register_1 = 5'd5;
    push2("rsv_pre_b1", BZ1, 0, 0);
    drain();
    cyc();
    push2("rsv_b1", BZ1, 1, 1);
    push2("rsv_cnt", CNT, 1, 1);
    drain();
    cyc();
    cyc();
    cyc();
    wr = 1'b1; write_register = 5'd5; write_data = 32'h12;
    push2("wb_b1", BZ1, 0, 1);
    push2("wb_rd1", RD1, 32'h12, 32'h0);
    push2("wb_cnt_pre", CNT, 1, 1);
    drain();
    cyc();
    push2("wb_cnt", CNT, 0, 0);
    push2("wb_b1_post", BZ1, 0, 0);
    push2("wb_rd1_post", RD1, 32'h12, 32'h12);
    drain();

    // same-cycle write and reserve of r7, then a double reserve
    wr = 1'b1; rsv = 1'b1; write_register = 5'd7; rsv_register = 5'd7; write_data = 32'h55;
    read_register_1 = 5'd7;
    cyc();
    push2("wr_rsv_rd1", RD1, 32'h55, 32'h55);
    push2("wr_rsv_b1", BZ1, 1, 1);
    push2("wr_rsv_cnt", CNT, 1, 1);
    push2("wr_rsv_err", ERR, 0, 0);
    drain();
    rsv = 1'b1; rsv_register = 5'd7;
    cyc();
    push2("dbl_err", ERR, 1, 1);
    push2("dbl_cnt", CNT, 1, 1);
    drain();
    cyc();
    push2("sticky_err", ERR, 1, 1);
    drain();
    wr = 1'b1; write_register = 5'd7; write_data = 32'h56;
    cyc();
    push2("r7_clr_cnt", CNT, 0, 0);
    drain();

    // register 0: hardwired zero on instance a, ordinary on instance b
    wr = 1'b1; rsv = 1'b1; write_register = 5'd0; rsv_register = 5'd0;
    write_data = 32'hFFFFFFFF; read_register_1 = 5'd0; read_register_2 = 5'd0;
    push2("z_pre_rd1", RD1, 0, 0);
    push2("z_pre_b2", BZ2, 0, 0);
    drain();
    cyc();
    push2("z_rd1", RD1, 0, 32'hFFFFFFFF);
    push2("z_rd2", RD2, 0, 32'hFFFFFFFF);
    push2("z_b1", BZ1, 0, 1);
    push2("z_cnt", CNT, 0, 1);
    drain();
    wr = 1'b1; write_register = 5'd0; write_data = 32'hFFFFFFFF;
    cyc();
    push2("z_clr_cnt", CNT, 0, 0);
    drain();

    // fill the scoreboard r1..r31, then drain it with write-backs
    for (int i = 1; i < 32; i++) begin
      rsv = 1'b1; rsv_register = 5'(i);
      cyc();
    end
    push2("fill_cnt", CNT, 31, 31);
    drain();
    for (int i = 1; i < 32; i++) begin
      wr = 1'b1; write_register = 5'(i); write_data = 32'h1000 + 32'(i);
      read_register_2 = 5'(i);
      push("drn_rd2_a", RD2, 32'h1000 + 32'(i));
      push("drn_b2_a", BZ2, 0);
      push("drn_b2_b", BZ2 + OFS_B, 1);
      drain();
      cyc();
    end
    push2("drn_cnt", CNT, 0, 0);
    read_register_1 = 5'd9;
    push2("drn_rd9", RD1, 32'h1009, 32'h1009);
    drain();
    wr = 1'b1; write_register = 5'd1; write_data = 32'h77;
    cyc();
    push2("extra_cnt", CNT, 0, 0);
    push2("extra_err", ERR, 1, 1);
    drain();

    // asynchronous reset in the middle of a cycle with live data and a reservation
    rsv = 1'b1; rsv_register = 5'd2; read_register_1 = 5'd2; read_register_2 = 5'd31;
    cyc();
    push2("pre_rst_b1", BZ1, 1, 1);
    push2("pre_rst_rd2", RD2, 32'h101F, 32'h101F);
    push2("pre_rst_cnt", CNT, 1, 1);
    drain();
    #2 rst = 1'b0;
    push2("arst_rd1", RD1, 0, 0);
    push2("arst_rd2", RD2, 0, 0);
    push2("arst_b1", BZ1, 0, 0);
    push2("arst_cnt", CNT, 0, 0);
    push2("arst_err", ERR, 0, 0);
    drain();
    #3 rst = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the multicycle datapath: 2 asynchronous read ports, 1 synchronous write port, plus a per-register busy scoreboard.
- The control FSM reserves a destination at issue and the write-back clears the reservation.
- Optional write-to-read bypass and optional hardwired zero register.
- The scoreboard lets the FSM stall on RAW hazards when long-latency units (mul/div, memory) complete out of step with issue.

Parameters:
WIDTH, 32, data width in bits
DEPTH, 5, address width; register count N = 2**DEPTH
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
write_data  input  WIDTH  write-back data
write_register  input  DEPTH  write-back address
wr  input  1  write enable; also clears the busy bit of write_register
rsv  input  1  reserve enable: mark rsv_register busy
rsv_register  input  DEPTH  register to reserve
read_register_1  input  DEPTH  read port 1 address
read_register_2  input  DEPTH  read port 2 address
read_data_1  output  WIDTH  read port 1 data (combinational)
read_data_2  output  WIDTH  read port 2 data (combinational)
busy_1  output  1  read_register_1 has an outstanding reservation (combinational)
busy_2  output  1  read_register_2 has an outstanding reservation (combinational)
busy_count  output  DEPTH+1  number of busy registers (registered)
rsv_err  output  1  sticky: reserve issued to an already-busy register

Behaviour:
- Reset (rst=0, async): all registers 0, all busy bits 0, busy_count 0, rsv_err 0. Reads then return 0 and busy_1/busy_2 are 0. Reset mid-operation discards all data and reservations immediately.
- Effective write: wr=1 and not (ZERO_REG=1 and write_register=0). On the next edge, mem[write_register] gets write_data and busy[write_register] is cleared.
- Effective reserve: rsv=1 and not (ZERO_REG=1 and rsv_register=0). On the next edge, busy[rsv_register] is set.
- Same register written and reserved in one cycle: data is written and the busy bit ends set (the new producer wins).
- Different registers written and reserved in one cycle: both take effect.
- Write to a non-busy register: the data is written and the busy bit stays 0. This is legal and not an error.
- Reserve of an already-busy register: the bit stays 1 and rsv_err is set (sticky until reset). Exception: if the same cycle carries an effective write to that register, no error is flagged.
- busy_count: next = current + (reserve sets a 0 bit) − (write clears a 1 bit without a same-register reserve). It never exceeds N (or N−1 when ZERO_REG=1). It never underflows.
- Read port x, combinational:
  - ZERO_REG=1 and addr=0: data 0, busy_x 0.
  - Otherwise, if BYPASS=1 and effective write to addr: data = write_data, busy_x = 0.
  - Otherwise: data = mem[addr], busy_x = busy[addr].
- A reserve in the current cycle never affects busy_x until after the edge.
- BYPASS=0: a read of the register being written returns the old value and the old busy bit for that cycle.
- rd port removed; reads are always enabled.
- Latency: write visible to reads one cycle after the edge (same cycle with BYPASS=1). Busy set/clear visible after the edge.

Test Plan:
- Reset with rst=0 mid-run after writes → read_data_1/2=0, busy_count=0, rsv_err=0 immediately, without waiting for a clock edge.
- wr=1, write_register=3, write_data=0xDEADBEEF, read_register_1=3: BYPASS=1 → read_data_1=0xDEADBEEF in the same cycle. BYPASS=0 → 0 that cycle, 0xDEADBEEF the next.
- rsv r5 at cycle 0 → busy_1=1 (read_register_1=5) from cycle 1, busy_count=1. At cycle 4, wr r5=0x12 → busy_1=0 combinationally (BYPASS=1), busy_count=0 at cycle 5.
- Same cycle rsv r7 and wr r7=0x55 → mem[7]=0x55, busy[7]=1, busy_count+1, rsv_err stays 0. Then rsv r7 again without wr → rsv_err=1 and stays 1.
- ZERO_REG=1: wr r0=0xFFFFFFFF and rsv r0 → read r0=0, busy=0, busy_count unchanged. ZERO_REG=0: read r0=0xFFFFFFFF.
- Reserve r1..r31 on consecutive cycles → busy_count=31. Then write all of them → busy_count returns to 0 with no underflow. An extra write to r1 leaves busy_count at 0.
